// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer arbiter: VGA scan-out reads win, CPU requests queue for idle cycles
// Optional statistics (stall_cnt, max_occ, stats_clr) enabled by defining VGA_FB_ARB_STATS_EN.
module vga_fb_arbiter #(
  parameter int DEPTH   = 4,
  parameter int DW      = 24,
  parameter int MAX_ROW = 480,
  parameter int MAX_COL = 640
) (
  input  logic          vga_clk,
  input  logic          clrn,
  input  logic          vga_rdn,
  input  logic [8:0]    vga_row,
  input  logic [9:0]    vga_col,
  output logic [DW-1:0] vga_d,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [8:0]    cpu_row,
  input  logic [9:0]    cpu_col,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_ovf,
  output logic [18:0]   mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
  ,
  input  logic          stats_clr,
  output logic [15:0]   stall_cnt,
  output logic [4:0]    max_occ
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + 9 + 10 + DW;
  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  SERVE = 2'd1;
  localparam logic [1:0]  HOLD  = 2'd2;
  localparam logic [9:0]  ROW_LIM = 10'(MAX_ROW);
  localparam logic [10:0] COL_LIM = 11'(MAX_COL);
  localparam logic [AW:0] OCC_ONE = (AW+1)'(1);

  logic [EW-1:0] fifo_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d, ovf_q, ovf_d;

  logic [AW:0]   occ;
  logic          empty, full, push, pop;
  logic          head_we, head_ok;
  logic [8:0]    head_row;
  logic [9:0]    head_col;
  logic [DW-1:0] head_wdata;

  assign occ       = wr_ptr_q - rd_ptr_q;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
  assign cpu_ready = ~full;
  assign push      = cpu_req & ~full;
  // The head is only served on cycles the scan-out engine leaves the RAM alone.
  assign pop       = vga_rdn & ~empty;

  assign {head_we, head_row, head_col, head_wdata} = fifo_q[rd_ptr_q[AW-1:0]];
  assign head_ok = ({1'b0, head_row} < ROW_LIM) && ({1'b0, head_col} < COL_LIM);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    vga_d     = '0;
    if (!vga_rdn) begin
      mem_addr = {vga_row, vga_col};
      vga_d    = mem_rdata;
    end else if (!empty) begin
      mem_addr  = {head_row, head_col};
      mem_we    = head_we & head_ok;
      mem_wdata = head_wdata;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (push) fifo_q[wr_ptr_q[AW-1:0]] <= {cpu_we, cpu_row, cpu_col, cpu_wdata};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + OCC_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + OCC_ONE;

    state_d = state_q;
    case (state_q)
      IDLE:        if (push) state_d = SERVE;
      SERVE, HOLD: begin
        if (!vga_rdn)                            state_d = HOLD;
        else if (pop && occ == OCC_ONE && !push) state_d = IDLE;
        else                                     state_d = SERVE;
      end
      default:     state_d = IDLE;
    endcase

    // Out-of-range reads still return a pulse, with zero data.
    rvalid_d = pop & ~head_we;
    rdata_d  = rdata_q;
    if (pop && !head_we) rdata_d = head_ok ? mem_rdata : '0;
    ovf_d = ovf_q | (cpu_req & full);
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_ovf    = ovf_q;

`ifdef VGA_FB_ARB_STATS_EN
  logic [15:0] stall_q;
  logic [4:0]  peak_q;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      stall_q <= '0;
      peak_q  <= '0;
    end else if (stats_clr) begin
      stall_q <= '0;
      peak_q  <= '0;
    end else begin
      if (state_q == HOLD && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (5'(occ) > peak_q) peak_q <= 5'(occ);
    end
  end

  assign stall_cnt = stall_q;
  assign max_occ   = peak_q;
`endif
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares a single-port pixel frame-buffer RAM between two requesters: the 640x480 VGA scan-out engine and a CPU/drawing-engine port.
- VGA reads have absolute priority whenever the scan-out read strobe is active.
- CPU writes and reads are queued in a small FIFO and drained only on cycles the VGA engine leaves the RAM idle (blanking intervals).
- Sits between the VGA timing generator and the frame-buffer RAM; the RAM has a combinational read path.

Parameters:
- DEPTH, 4, CPU request FIFO entries; power of two, range 2..16.
- DW, 24, pixel width (rrrrrrrr_gggggggg_bbbbbbbb).
- MAX_ROW, 480, rows at or above this value are out of range.
- MAX_COL, 640, columns at or above this value are out of range.

Ports:
- vga_clk  in  1  pixel clock, 25 MHz; all logic on rising edge.
- clrn  in  1  asynchronous active-low reset.
- vga_rdn  in  1  scan-out read strobe, active low.
- vga_row  in  9  scan-out row address.
- vga_col  in  10  scan-out column address.
- vga_d  out  DW  pixel data to the scan-out engine.
- cpu_req  in  1  request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_row  in  9  request row.
- cpu_col  in  10  request column.
- cpu_wdata  in  DW  write data.
- cpu_ready  out  1  FIFO not full; a request is accepted when cpu_req && cpu_ready.
- cpu_rdata  out  DW  read return data.
- cpu_rvalid  out  1  one-cycle pulse qualifying cpu_rdata.
- cpu_ovf  out  1  sticky flag: a request arrived while the FIFO was full.
- mem_addr  out  19  RAM address, {row[8:0], col[9:0]}.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, combinational from mem_addr.

Behaviour:
- Reset values:
  - cpu_rdata = 0, cpu_rvalid = 0, cpu_ovf = 0.
  - FIFO empty; cpu_ready = 1.
  - FSM in IDLE.
- Combinational mux, VGA owner (vga_rdn = 0):
  - mem_addr = {vga_row, vga_col}, mem_we = 0.
  - vga_d = mem_rdata.
  - The FIFO head is held.
- Combinational mux, CPU owner (vga_rdn = 1 and FIFO not empty):
  - mem_addr = {head.row, head.col}.
  - mem_we = head.we && in_range(head).
  - mem_wdata = head.wdata.
  - vga_d = 0.
- Combinational mux, idle (vga_rdn = 1 and FIFO empty): mem_addr = 0, mem_we = 0, vga_d = 0.
- FSM states:
  - IDLE: FIFO empty. Go to SERVE when the FIFO becomes non-empty.
  - SERVE: on each cycle with vga_rdn = 1, pop the head. Return to IDLE when the last entry pops and no push occurs in that cycle.
  - HOLD: entered from SERVE when vga_rdn = 0. Stays in HOLD while vga_rdn = 0. Returns to SERVE when vga_rdn goes to 1.
- Read return: when a read entry pops, register mem_rdata into cpu_rdata and assert cpu_rvalid for exactly the next cycle.
  - Latency from pop to cpu_rvalid is 1 cycle.
  - Minimum latency from acceptance to cpu_rvalid is 2 cycles.
  - Read data is returned in FIFO order.
- Out-of-range requests (row >= MAX_ROW or col >= MAX_COL):
  - Writes pop with mem_we = 0.
  - Reads pop and return cpu_rdata = 0 with cpu_rvalid still pulsed.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits wide; full when the pointers differ only in the MSB.
  - Simultaneous push and pop when full is not allowed: cpu_ready = 0 blocks the push.
  - Simultaneous push and pop at any other occupancy keeps occupancy unchanged.
  - A push into an empty FIFO is not served in the same cycle; the entry is first visible the next cycle.
- Overflow: cpu_req = 1 while cpu_ready = 0 sets cpu_ovf. The request is dropped and cpu_ovf stays set until reset.
- Reset mid-operation: the FIFO is flushed and any pending cpu_rvalid is cancelled. No RAM write is issued while clrn = 0.

Optional Feature:
- Macro: VGA_FB_ARB_STATS_EN.
- When defined, the block adds:
  - Output stall_cnt[15:0]: counts cycles in HOLD; saturates at 16'hFFFF.
  - Output max_occ[4:0]: records the peak FIFO occupancy.
  - Input stats_clr: synchronous clear of both stall_cnt and max_occ.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Write during blanking: reset, vga_rdn = 1, one write (row 5, col 7, wdata 24'hFF0000) -> next cycle mem_we = 1, mem_addr = {9'd5, 10'd7}, mem_wdata = 24'hFF0000; FIFO empty afterwards.
- Write deferred by scan-out: vga_rdn = 0 for 10 cycles with a write queued -> mem_we = 0 and mem_addr tracks vga_row/vga_col throughout; the write issues on the first cycle vga_rdn = 1.
- Read return: write (1, 1) = 24'h123456, then read (1, 1) with vga_rdn = 1 -> cpu_rvalid pulses 1 cycle with cpu_rdata = 24'h123456, 2 cycles after acceptance.
- Full FIFO: vga_rdn = 0 and 4 requests accepted -> cpu_ready = 0. A 5th request -> cpu_ovf = 1, dropped. Release vga_rdn -> exactly 4 pops.
- Out-of-range: write at row 480 -> mem_we stays 0. Read at col 700 -> cpu_rvalid pulses with cpu_rdata = 0.
- Reset mid-drain: 3 entries queued, assert clrn low for 1 cycle -> cpu_ready = 1, no mem_we, no cpu_rvalid, cpu_ovf = 0.
